// File: rtl/fft_feed_pkg.sv
// Shared constants, state encoding and Hann coefficient helper for the FFT window feeder.
// The Hann window path is compiled only when FFT_WINDOW_EN is defined.
package fft_feed_pkg;

    localparam int FFT_POINTS   = 1024;
    localparam int SAMPLE_WIDTH = 8;
    localparam int OUT_WIDTH    = 16;
    localparam int COEF_WIDTH   = 16;

    localparam int IDX_WIDTH    = $clog2(FFT_POINTS);
    localparam int PROD_WIDTH   = 24;
    localparam int ADC_OFFSET   = 128;
    localparam int ROUND_CONST  = 64;
    localparam int ROUND_SHIFT  = 7;
    localparam int BUF_DEPTH    = 4;
    localparam int CREDITS      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_e;

    // Elaboration-time coefficient: min(32767, round(32768 * 0.5 * (1 - cos(2*pi*n/N)))).
    function automatic logic [COEF_WIDTH-1:0] hann_coef(input int n);
        real c;
        int  r;
        c = 16384.0 * (1.0 - $cos(2.0 * 3.141592653589793 * n / FFT_POINTS));
        r = $rtoi(c + 0.5);
        if (r > 32767) r = 32767;
        return COEF_WIDTH'(r);
    endfunction

endpackage

// File: rtl/hann_coef_rom.sv
// Synchronous Hann window coefficient ROM, FFT_POINTS x COEF_WIDTH, one-cycle read latency.
// Instantiated by fft_window_feeder only when FFT_WINDOW_EN is defined.
module hann_coef_rom
    import fft_feed_pkg::*;
(
    input  logic                  clk,
    input  logic [IDX_WIDTH-1:0]  addr_i,
    output logic [COEF_WIDTH-1:0] coef_o
);

    logic [COEF_WIDTH-1:0] rom_w [FFT_POINTS];
    logic [COEF_WIDTH-1:0] coef_q;

    for (genvar i = 0; i < FFT_POINTS; i++) begin : g_rom
        assign rom_w[i] = hann_coef(i);
    end

    always_ff @(posedge clk) begin
        coef_q <= rom_w[addr_i];
    end

    assign coef_o = coef_q;

endmodule

// File: rtl/fft_window_feeder.sv
// Reads FFT_POINTS offset-binary samples per frame, windows them and streams them over AXI4-Stream.
// Define FFT_WINDOW_EN for the Hann window; otherwise a rectangular window (s <<< 8) is used.
module fft_window_feeder
    import fft_feed_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    fifo_rd_en,
    input  logic [SAMPLE_WIDTH-1:0] fifo_rd_data,
    input  logic                    fifo_rd_empty,
    output logic [OUT_WIDTH-1:0]    m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready
);

    feed_state_e                   state_q, state_d;
    logic [IDX_WIDTH-1:0]          rd_idx_q, rd_idx_d;
    logic [2:0]                    credit_q, credit_d;
    logic [2:0]                    count_q, count_d;
    logic [1:0]                    wr_ptr_q, rd_ptr_q;
    logic                          v1_q, last1_q, v2_q, last2_q;
    logic signed [PROD_WIDTH-1:0]  prod_q, prod_d;
    logic [OUT_WIDTH-1:0]          buf_data_q [BUF_DEPTH];
    logic                          buf_last_q [BUF_DEPTH];

    logic                          last_read, push, pop;
    logic signed [SAMPLE_WIDTH-1:0] sample_s;
    logic signed [PROD_WIDTH-1:0]  sample_ext;
    logic [OUT_WIDTH-1:0]          beat_data;

    assign last_read = (rd_idx_q == IDX_WIDTH'(FFT_POINTS - 1));
    assign push      = v2_q;
    assign pop       = m_axis_tvalid && m_axis_tready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fifo_rd_en && last_read) state_d = DRAIN;
            DRAIN:   if (pop && m_axis_tlast) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credits count reads issued but not yet popped, bounding in-flight plus buffered beats.
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        fifo_rd_en = 1'b0;
        unique case (state_q)
            RUN: begin
                busy       = 1'b1;
                fifo_rd_en = !fifo_rd_empty && (credit_q < 3'(CREDITS));
            end
            DRAIN:   busy = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rd_idx_d = rd_idx_q;
        if (state_q == IDLE && start) rd_idx_d = '0;
        else if (fifo_rd_en)          rd_idx_d = rd_idx_q + 1'b1;

        credit_d = credit_q;
        if (fifo_rd_en && !pop)      credit_d = credit_q + 3'd1;
        else if (!fifo_rd_en && pop) credit_d = credit_q - 3'd1;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 3'd1;
        else if (!push && pop) count_d = count_q - 3'd1;
    end

    assign sample_s   = fifo_rd_data - SAMPLE_WIDTH'(ADC_OFFSET);
    assign sample_ext = $signed({{(PROD_WIDTH - SAMPLE_WIDTH){sample_s[SAMPLE_WIDTH-1]}}, sample_s});

`ifdef FFT_WINDOW_EN
    logic [COEF_WIDTH-1:0]        coef;
    logic signed [PROD_WIDTH-1:0] coef_ext;

    hann_coef_rom u_rom (
        .clk    (clk),
        .addr_i (rd_idx_q),
        .coef_o (coef)
    );

    assign coef_ext = $signed(PROD_WIDTH'(coef));
    assign prod_d   = sample_ext * coef_ext;
`else
    // Unit gain in Q0.15, so the shared rounding stage below yields exactly s <<< 8.
    assign prod_d = sample_ext <<< (COEF_WIDTH - 1);
`endif

    assign beat_data = OUT_WIDTH'((prod_q + $signed(PROD_WIDTH'(ROUND_CONST))) >>> ROUND_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q <= '0;
            credit_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            prod_q   <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
            credit_q <= credit_d;
            count_q  <= count_d;
            v1_q     <= fifo_rd_en;
            last1_q  <= fifo_rd_en && last_read;
            v2_q     <= v1_q;
            last2_q  <= last1_q;
            prod_q   <= prod_d;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
        end
    end

    // NOTE: buffer storage is not reset; count_q alone decides which entries hold live beats.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= beat_data;
            buf_last_q[wr_ptr_q] <= last2_q;
        end
    end

    assign m_axis_tvalid = (count_q != 3'd0);
    assign m_axis_tdata  = m_axis_tvalid ? buf_data_q[rd_ptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && buf_last_q[rd_ptr_q];

endmodule
